// File: rtl/sum_window_avg.sv
// sum_window_avg: accumulates 2**LOG2_WIN samples and emits the window total and floor
// average through a one-entry output register. Optional min/max tracking: ACC_MINMAX_EN.
module sum_window_avg #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   clear,
    output logic [DATA_W+LOG2_WIN-1:0]             out_sum,
    output logic [DATA_W-1:0]                      out_avg,
    output logic                                   out_valid,
    input  logic                                   out_ready,
`ifdef ACC_MINMAX_EN
    output logic [DATA_W-1:0]                      out_min,
    output logic [DATA_W-1:0]                      out_max,
`endif
    output logic [((LOG2_WIN > 0) ? LOG2_WIN : 1)-1:0] win_cnt
);

    localparam int SUM_W = DATA_W + LOG2_WIN;
    localparam int CNT_W = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_WIN) - 1);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } slot_t;

    slot_t              r_state;
    slot_t              w_state_next;
    logic [SUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_win_cnt;
    logic [SUM_W-1:0]   r_out_sum;
    logic [DATA_W-1:0]  r_out_avg;
    logic [SUM_W-1:0]   w_sum;
    logic               w_last_slot;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_final;

    assign w_last_slot = (r_win_cnt == LAST);
    // Only the final sample stalls on a pending result; earlier samples keep accumulating.
    assign w_in_ready  = !clear && !rst && !((r_state == S_FULL) && !out_ready && w_last_slot);
    assign w_accept    = in_valid && w_in_ready;
    assign w_final     = w_accept && w_last_slot;
    assign w_sum       = r_acc + SUM_W'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_final) w_state_next = S_FULL;
            S_FULL:  if (!w_final && out_ready) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_out_sum <= '0;
            r_out_avg <= '0;
        end else if (clear) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
        end else if (w_final) begin
            r_out_sum <= w_sum;
            r_out_avg <= DATA_W'(w_sum >> LOG2_WIN);
            r_acc     <= '0;
            r_win_cnt <= '0;
        end else if (w_accept) begin
            r_acc     <= w_sum;
            r_win_cnt <= r_win_cnt + CNT_W'(1);
        end
    end

`ifdef ACC_MINMAX_EN
    logic [DATA_W-1:0] r_run_min;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_out_min;
    logic [DATA_W-1:0] r_out_max;
    logic [DATA_W-1:0] w_min_next;
    logic [DATA_W-1:0] w_max_next;

    // The first sample of each window seeds the running extremes.
    always_comb begin
        w_min_next = in_data;
        w_max_next = in_data;
        if (r_win_cnt != '0) begin
            if (r_run_min < in_data) w_min_next = r_run_min;
            if (r_run_max > in_data) w_max_next = r_run_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_min <= '0;
            r_run_max <= '0;
            r_out_min <= '0;
            r_out_max <= '0;
        end else if (clear) begin
            r_run_min <= '0;
            r_run_max <= '0;
        end else if (w_final) begin
            r_out_min <= w_min_next;
            r_out_max <= w_max_next;
            r_run_min <= '0;
            r_run_max <= '0;
        end else if (w_accept) begin
            r_run_min <= w_min_next;
            r_run_max <= w_max_next;
        end
    end

    assign out_min = r_out_min;
    assign out_max = r_out_max;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_FULL);
    assign out_sum   = r_out_sum;
    assign out_avg   = r_out_avg;
    assign win_cnt   = r_win_cnt;

endmodule

// File: tb/tb_sum_window_avg.sv
// Scoreboard bench for sum_window_avg (DATA_W=8, LOG2_WIN=2): driver queues expected
// results, a negedge monitor checks each consumed output against the queue.
module tb_sum_window_avg;

    localparam int DATA_W   = 8;
    localparam int LOG2_WIN = 2;

    typedef struct {
        int sum;
        int avg;
        int mn;
        int mx;
    } exp_t;

    logic                       clk;
    logic                       rst;
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       clear;
    logic [DATA_W+LOG2_WIN-1:0] out_sum;
    logic [DATA_W-1:0]          out_avg;
    logic                       out_valid;
    logic                       out_ready;
    logic [LOG2_WIN-1:0]        win_cnt;
`ifdef ACC_MINMAX_EN
    logic [DATA_W-1:0]          out_min;
    logic [DATA_W-1:0]          out_max;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    sum_window_avg #(
        .DATA_W  (DATA_W),
        .LOG2_WIN(LOG2_WIN)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef ACC_MINMAX_EN
        .out_min  (out_min),
        .out_max  (out_max),
`endif
        .win_cnt  (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int s, input int a, input int mn, input int mx);
        exp_t e;
        e.sum = s; e.avg = a; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
    endtask

    // Present a sample and hold it until accepted (bounded).
    task automatic send(input int d);
        int unsigned n = 0;
        in_data  = DATA_W'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(out_sum), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", int'(out_sum), e.sum);
                chk("out_avg", int'(out_avg), e.avg);
`ifdef ACC_MINMAX_EN
                chk("out_min", int'(out_min), e.mn);
                chk("out_max", int'(out_max), e.mx);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_in_reset", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_avg", int'(out_avg), 0);
        chk("rst_win_cnt", int'(win_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Basic window with one-cycle latency
        push(100, 25, 10, 40);
        send(10); send(20); send(30);
        chk("basic_win_cnt3", int'(win_cnt), 3);
        chk("basic_no_valid_early", int'(out_valid), 0);
        send(40);
        chk("basic_latency_valid", int'(out_valid), 1);
        chk("basic_latency_sum", int'(out_sum), 100);
        chk("basic_win_cnt0", int'(win_cnt), 0);

        // Full-scale total and floor average
        push(1020, 255, 255, 255);
        send(255); send(255); send(255); send(255);
        push(9, 2, 1, 3);
        send(1); send(2); send(3); send(3);
        idle(2);

        // Backpressure: only the final sample of the second window stalls
        out_ready = 1'b0;
        push(4, 1, 1, 1);
        push(4, 1, 1, 1);
        send(1); send(1); send(1); send(1);
        send(1); send(1); send(1);
        chk("bp_win_cnt3", int'(win_cnt), 3);
        in_data = 8'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall_in_ready", int'(in_ready), 0);
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_sum", int'(out_sum), 4);
        @(negedge clk);
        chk("bp_hold_sum2", int'(out_sum), 4);
        chk("bp_hold_avg2", int'(out_avg), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_reload_valid", int'(out_valid), 1);
        chk("bp_reload_sum", int'(out_sum), 4);
        chk("bp_reload_win_cnt", int'(win_cnt), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(2);

        // Clear drops the partial window and refuses the same-cycle sample
        push(10, 2, 1, 4);
        send(5); send(5);
        chk("clr_win_cnt2", int'(win_cnt), 2);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd9;
        @(negedge clk);
        chk("clr_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_win_cnt0", int'(win_cnt), 0);
        @(posedge clk); #1;
        send(1); send(2); send(3); send(4);
        idle(2);

        // Reset mid-window
        send(7); send(7); send(7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_sum", int'(out_sum), 0);
        chk("mid_rst_out_avg", int'(out_avg), 0);
        chk("mid_rst_win_cnt", int'(win_cnt), 0);
        @(posedge clk); #1;
        push(4, 1, 1, 1);
        send(1); send(1); send(1);
        chk("mid_rst_no_spurious", int'(out_valid), 0);
        send(1);
        idle(2);

`ifdef ACC_MINMAX_EN
        push(20, 5, 1, 9);
        send(7); send(3); send(9); send(1);
        push(16, 4, 4, 4);
        send(4); send(4); send(4); send(4);
        idle(2);
`endif

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_window_avg.md
Name: sum_window_avg

Overview:
- Downstream consumer of the 8-bit adder result (ui_in + uio_in) on the tt_um top level.
- Accepts sum samples over a valid/ready handshake and accumulates a fixed window of 2^LOG2_WIN samples.
- At the end of each window, emits the window total and the truncated average through a one-entry output register with its own valid/ready handshake.
- Drives uo_out (average) in the top-level integration. The higher total bits go to uio_out.

Parameters:
- DATA_W, 8, width of each input sample and of out_avg.
- LOG2_WIN, 2, log2 of the window length. Legal range is 0..4, so the window is 1..16 samples.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; synchronous, active-high
- in_data  input  DATA_W  sum sample from the adder stage
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- clear  input  1  synchronous flush of the partial window
- out_sum  output  DATA_W+LOG2_WIN  window total
- out_avg  output  DATA_W  out_sum >> LOG2_WIN
- out_valid  output  1  output register holds an unconsumed result
- out_ready  input  1  consumer accepts the result
- win_cnt  output  LOG2_WIN (min 1)  samples accepted in the current window
- out_min, out_max  output  DATA_W each  present only with ACC_MINMAX_EN

Behaviour:
- Reset (rst=1 at a clk edge): acc, win_cnt, out_sum, out_avg, out_min and out_max clear to 0. out_valid clears to 0. in_ready reads 0 during the reset cycle and 1 afterwards.
- Reset mid-window or with a result pending discards everything, with no output pulse.
- Accept event: in_valid && in_ready at a clk edge.
- Each accept adds in_data to acc and increments win_cnt.
- Width rule: acc is DATA_W+LOG2_WIN bits wide, so it cannot overflow. The largest total is (2^DATA_W-1)·2^LOG2_WIN.
- Final sample: an accept with win_cnt == 2^LOG2_WIN-1 is the last sample of the window. On that edge:
  - out_sum <= acc + in_data and out_avg <= (acc + in_data) >> LOG2_WIN (floor).
  - out_valid <= 1.
  - acc and win_cnt clear to 0.
- Latency: out_valid is visible in the cycle after the final accepting edge.
- Output slot FSM, EMPTY (out_valid=0) / FULL (out_valid=1):
  - EMPTY -> FULL on a final-sample accept.
  - FULL -> EMPTY on out_ready with no simultaneous final-sample accept.
  - FULL stays FULL when out_ready and a final-sample accept coincide. The register reloads with the new result and there is no bubble.
- Output stability: out_sum, out_avg, out_min and out_max hold stable while out_valid && !out_ready.
- in_ready is combinational: !clear && !rst && !(out_valid && !out_ready && win_cnt == 2^LOG2_WIN-1).
  - Samples of the next window keep accumulating while a result is pending.
  - Only the final sample of a window stalls on backpressure.
- clear:
  - Zeroes acc and win_cnt.
  - Forces in_ready=0, so a sample presented in the same cycle is not consumed.
  - Does not touch the output slot or out_valid.
- LOG2_WIN=0: every accept is a final sample, with out_sum = out_avg = in_data and win_cnt fixed at 0.
- Wrap-around: win_cnt rolls 2^LOG2_WIN-1 -> 0 only via the final-sample path. It never counts past the window.

Optional Feature:
- Macro: ACC_MINMAX_EN.
- Defined:
  - Block tracks a running min and max of the window's samples, seeded by the first sample of each window.
  - out_min and out_max are latched alongside out_sum on the final-sample edge, with the same stability and reset rules.
  - clear also resets the running min/max seed.
- Undefined: out_min and out_max ports and their tracking logic are absent. All other behaviour is identical.

Test Plan:
- Basic window: LOG2_WIN=2, out_ready=1, feed 10,20,30,40 on back-to-back cycles. Required: one cycle after the 40 accept, out_valid=1, out_sum=100, out_avg=25, win_cnt=0.
- Max / width: feed 255,255,255,255. Required: out_sum=1020 (10 bits, no wrap), out_avg=255. Then feed 1,2,3,3. Required: out_sum=9, out_avg=2 (floor).
- Backpressure: hold out_ready=0 and feed 8 samples of value 1.
  - Required: first result out_sum=4 held stable.
  - Samples 5-7 accepted; sample 8 sees in_ready=0.
  - Raise out_ready for one cycle: sample 8 is accepted in that cycle, and the next cycle shows out_sum=4 with out_valid=1 (second window).
- Clear: feed 5,5, then clear with in_valid=1 and in_data=9 in the same cycle, then 1,2,3,4. Required: the 9 is not accepted, out_sum=10, out_avg=2.
- Reset mid-operation: feed 7,7,7, then assert rst for one cycle, then 1,1,1,1. Required: all outputs 0 after rst, and the next result is out_sum=4 with no spurious out_valid before it.
- ACC_MINMAX_EN defined: feed 7,3,9,1. Required: out_min=1, out_max=9. Next window 4,4,4,4 gives out_min=out_max=4 (seed resets per window).
